data_reg_reader: RTL and testbench

Readback sequencer for the ten-entry 32-bit data register bank. On a start pulse it snapshots the bank's ten parallel outputs into a private buffer, then streams them out one word per handshake, tagged with the 4-bit register address. It also produces a running 32-bit modular sum for host-side integrity checks. It sits between the register bank outputs and the host/debug readout path, so the bank can be rewritten while a readback drains.

---
 rtl/data_bank_pkg.sv | 8 +
 rtl/data_snapshot_buf.sv | 21 ++
 rtl/data_reg_reader.sv | 96 +++++++++
 tb/tb_data_reg_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/data_bank_pkg.sv
// data_bank_pkg: constants and reader state shared by the data register bank and its readback sequencer.
package data_bank_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int NUM_REGS = 10;
  localparam int ADDR_WIDTH = 4;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = 4'd9;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} reader_state_e;
endpackage

// File: rtl/data_snapshot_buf.sv
// data_snapshot_buf: load-all register file that freezes the bank outputs for one readback.
module data_snapshot_buf
  import data_bank_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [WIDTH-1:0]      din [DEPTH],
  input  logic [ADDR_WIDTH-1:0] idx,
  output logic [WIDTH-1:0]      dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) mem <= '{default: '0};
    else if (load) mem <= din;
  // Out-of-range reads (one past the last word) return zero and are never used.
  assign dout = (idx < ADDR_WIDTH'(DEPTH)) ? mem[idx] : '0;
endmodule

// File: rtl/data_reg_reader.sv
// data_reg_reader: snapshots the ten-entry register bank on start and streams it out
// with valid/ready handshake, address tags and a running modulo-2^WIDTH sum.
module data_reg_reader
  import data_bank_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int NUM_WORDS = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [WIDTH-1:0]      in0,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  input  logic [WIDTH-1:0]      in3,
  input  logic [WIDTH-1:0]      in4,
  input  logic [WIDTH-1:0]      in5,
  input  logic [WIDTH-1:0]      in6,
  input  logic [WIDTH-1:0]      in7,
  input  logic [WIDTH-1:0]      in8,
  input  logic [WIDTH-1:0]      in9,
  input  logic                  start,
  output logic [WIDTH-1:0]      dataOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  lastOut,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      sumOut
);
  localparam logic [ADDR_WIDTH-1:0] last_addr = ADDR_WIDTH'(NUM_WORDS - 1);
  reader_state_e state;
  logic [ADDR_WIDTH-1:0] idx, nxt_idx;
  logic [WIDTH-1:0] bank [NUM_REGS];
  logic [WIDTH-1:0] rd_data;
  logic load, accept;
  assign bank = '{in0, in1, in2, in3, in4, in5, in6, in7, in8, in9};
  assign load = (state == IDLE) && start;
  assign accept = outValid && outReady;
  assign nxt_idx = idx + 1'b1;
  assign addrOut = idx;
  // The buffer is read one word ahead so dataOut can be registered on each accept.
  data_snapshot_buf #(.WIDTH(WIDTH), .DEPTH(NUM_REGS)) u_buf (
    .clk(clk),
    .resetN(resetN),
    .load(load),
    .din(bank),
    .idx(nxt_idx),
    .dout(rd_data)
  );
  // Word 0 comes straight from the bank because the buffer captures on the same edge.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      idx <= '0;
      dataOut <= '0;
      outValid <= 1'b0;
      lastOut <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sumOut <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state <= STREAM;
            idx <= '0;
            dataOut <= in0;
            outValid <= 1'b1;
            lastOut <= (last_addr == '0);
            busy <= 1'b1;
            sumOut <= '0;
          end
        STREAM:
          if (accept) begin
            sumOut <= sumOut + dataOut;
            if (idx == last_addr) begin
              state <= DONE;
              outValid <= 1'b0;
              lastOut <= 1'b0;
              done <= 1'b1;
            end else begin
              idx <= nxt_idx;
              dataOut <= rd_data;
              lastOut <= (nxt_idx == last_addr);
            end
          end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_reg_reader.sv
// tb_data_reg_reader: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_data_reg_reader;
  logic clk = 1'b0, resetN = 1'b0, start = 1'b0, outReady = 1'b0;
  logic [31:0] in_v [10];
  logic [31:0] dataOut, sumOut;
  logic [3:0] addrOut;
  logic outValid, lastOut, busy, done;
  typedef struct {logic [3:0] a; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0, busy_cnt = 0, rdy_mode = 0, rdy_cnt = 0;
  logic held_v = 1'b0, held_l;
  logic [31:0] held_d;
  logic [3:0] held_a;

  data_reg_reader dut (
    .clk(clk), .resetN(resetN),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]), .in4(in_v[4]),
    .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]), .in8(in_v[8]), .in9(in_v[9]),
    .start(start), .dataOut(dataOut), .addrOut(addrOut), .outValid(outValid),
    .outReady(outReady), .lastOut(lastOut), .busy(busy), .done(done), .sumOut(sumOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    outReady = (rdy_mode == 0) || (rdy_cnt % 3 == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!resetN) held_v = 1'b0;
    else begin
      if (held_v) begin
        chk("hold_valid", outValid, 1);
        chk("hold_data", dataOut, held_d);
        chk("hold_addr", addrOut, held_a);
        chk("hold_last", lastOut, held_l);
      end
      if (outValid && outReady) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", dataOut, e.d);
          chk("addr", addrOut, e.a);
          chk("last", lastOut, e.a == 4'd9);
        end
      end
      held_v = outValid && !outReady;
      held_d = dataOut;
      held_a = addrOut;
      held_l = lastOut;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, dataOut, 0);
    chk({tag, "_addr"}, addrOut, 0);
    chk({tag, "_valid"}, outValid, 0);
    chk({tag, "_last"}, lastOut, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sumOut, 0);
  endtask

  task automatic start_run();
    foreach (in_v[k]) exp_q.push_back('{a: 4'(k), d: in_v[k]});
    done_cnt = 0;
    busy_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_for(input string name, input int addr);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (addr < 0 ? done : (outValid && addrOut == 4'(addr))) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic finish_run(input logic [31:0] exp_sum, input bit chk_busy);
    wait_for("done", -1);
    chk("sum", sumOut, exp_sum);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    if (chk_busy) chk("busy_span", busy_cnt, 11);
  endtask

  initial begin
    foreach (in_v[k]) in_v[k] = '0;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_zero("idle");
    end
    rdy_mode = 0;
    foreach (in_v[k]) in_v[k] = 32'h1000_0000 + k;
    start_run();
    finish_run(32'hA000_002D, 1'b1);
    rdy_mode = 1;
    start_run();
    finish_run(32'hA000_002D, 1'b0);
    rdy_mode = 0;
    start_run();
    foreach (in_v[k]) in_v[k] = 32'hFFFF_FFFF;
    wait_for("addr4", 4);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_run(32'hA000_002D, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart_valid", outValid, 0);
      chk("no_restart_busy", busy, 0);
    end
    start_run();
    finish_run(32'hFFFF_FFF6, 1'b1);
    foreach (in_v[k]) in_v[k] = 32'h2000_0000 + k;
    start_run();
    wait_for("addr6", 6);
    #1 resetN = 1'b0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    chk_zero("in_reset");
    @(posedge clk);
    #1 resetN = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_zero("post_reset");
    end
    foreach (in_v[k]) in_v[k] = 32'h11 * k;
    start_run();
    finish_run(32'h0000_02FD, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
